adc083000_cfg_sequencer: RTL and testbench
==========================================

Name: adc083000_cfg_sequencer

Overview:
Sequences configuration writes into the ADC083000 3-wire serial-interface serializer, which accepts one 4-bit address and 16-bit data word per start pulse and reports activity on chip_sel. The block runs a fixed power-up init table, then drains host register writes from a small FIFO. It enforces a chip-select idle gap between words, watches for a serializer that fails to start, and exposes status to the OPB register layer.

Parameters:
FIFO_DEPTH, 4, host write FIFO entries; power of 2, minimum 2
GAP_CYCLES, 4, sclk cycles spi_cs must stay low after a word before the next spi_start; minimum 1
START_TIMEOUT, 8, sclk cycles after spi_start within which spi_cs must rise
INIT_ENABLE, 1, 1 = run the init table automatically after reset

Ports:
sclk  in  1  serializer clock; the only clock in the block
reset_n  in  1  asynchronous, active-low reset
host_addr  in  4  register address of the host write
host_data  in  16  register data of the host write
host_valid  in  1  host write offered
host_ready  out  1  FIFO not full; a write is accepted when host_valid && host_ready
init_req  in  1  one-cycle pulse: rerun the init table
spi_addr  out  4  to serializer config_addr
spi_data  out  16  to serializer config_data
spi_start  out  1  to serializer config_start; one-cycle pulse
spi_cs  in  1  from serializer chip_sel
busy  out  1  FSM not in IDLE, or FIFO not empty, or init pending
init_done  out  1  init table fully sent since last reset/init_req
err_timeout  out  1  sticky: spi_cs failed to rise within START_TIMEOUT
err_clr  in  1  clears err_timeout
words_sent  out  16  count of words whose spi_cs high was observed; wraps 0xFFFF->0

Behaviour:
- Reset values: spi_start=0, spi_addr=0, spi_data=0, busy=0, init_done=0, err_timeout=0, words_sent=0, FIFO empty. host_ready=1, since host_ready = !full. With INIT_ENABLE=1, init is pending on the first cycle after reset release, so busy=1 from that cycle.
- FSM states and transitions:
  - IDLE -> LOAD when a word is available. Pending init has priority over the FIFO. Init entries go in index order 0..INIT_LEN-1.
  - LOAD (1 cycle): drive spi_addr/spi_data, spi_start=1, pop the FIFO if the word came from the host, clear the timeout counter -> WAIT_CS.
  - WAIT_CS: -> SHIFT on spi_cs=1, incrementing words_sent. After START_TIMEOUT cycles without spi_cs: set err_timeout, drop the word (no retry) -> GAP.
  - SHIFT: -> GAP on spi_cs=0.
  - GAP: count GAP_CYCLES cycles -> IDLE. If this was the last init word, set init_done on the exit cycle.
- spi_addr/spi_data are held stable from LOAD until the next LOAD, because the serializer samples them in its load cycle.
- Against the serializer: spi_start at cycle t gives spi_cs high at t+1..t+33. Word period = 1 (LOAD) + 1 + 33 + GAP_CYCLES cycles.
- init_req:
  - Clears init_done and marks init pending from index 0.
  - If a word is in flight, it completes first.
  - If the init table is already running, the table restarts from index 0 after the current word.
  - Host FIFO contents are retained and sent after init.
- FIFO full: host_ready=0 and the write is not accepted. A push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- err_clr and a new timeout in the same cycle: set wins.
- reset_n low mid-word: FSM to IDLE and FIFO flushed immediately. The serializer shares the system reset.

Decomposition:
- Package adc083000_cfg_pkg:
  - FSM state encoding (IDLE, LOAD, WAIT_CS, SHIFT, GAP).
  - INIT_LEN=4.
  - Init table INIT_ADDR/INIT_DATA: {1:16'hB2FF, 2:16'h007F, 3:16'h807F, 14:16'h00FF}.
- Sub-module adc083000_cfg_fifo: synchronous 20-bit FIFO (addr concatenated with data), FIFO_DEPTH deep, with full/empty flags and async active-low reset.

Test Plan:
- Release reset with a serializer model attached -> four spi_start pulses carrying addr/data 1/B2FF, 2/007F, 3/807F, E/00FF in that order. Consecutive starts are 39 cycles apart; init_done rises 4 cycles after the last spi_cs fall; words_sent=4.
- Push 5 host writes back-to-back during init with FIFO_DEPTH=4 -> host_ready drops after the 4th accept; the 5th is held until the first pop. All five are sent after init in push order.
- Model never raises spi_cs -> err_timeout set 8 cycles after spi_start. The word is dropped and the next word starts after the gap; err_clr clears the flag; err_clr together with a new timeout leaves the flag set.
- init_req pulse while a host word is in SHIFT -> the host word completes, the full init table is resent from index 0, and the remaining FIFO words follow; init_done goes 0 and then returns to 1.
- Assert reset_n low mid-SHIFT with 2 words queued -> outputs return to reset values; after release only the init table is sent.
- Preload words_sent to 0xFFFF via a long run or force -> the next word wraps it to 0.

Source files
------------

// File: rtl/adc083000_cfg_pkg.sv
// Shared types and the fixed power-up register table for the ADC083000
// configuration sequencer.
package adc083000_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_CS = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  localparam int INIT_LEN = 4;
  localparam int IDX_W    = 2;

  // One serializer word: 4-bit register address plus 16-bit register data.
  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } cfg_word_t;

  localparam int WORD_W = $bits(cfg_word_t);

  // Power-up register table, sent in index order.
  function automatic cfg_word_t init_word(input logic [IDX_W-1:0] idx);
    cfg_word_t w;
    case (idx)
      2'd0:    w = '{addr: 4'h1, data: 16'hB2FF};
      2'd1:    w = '{addr: 4'h2, data: 16'h007F};
      2'd2:    w = '{addr: 4'h3, data: 16'h807F};
      default: w = '{addr: 4'hE, data: 16'h00FF};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/adc083000_cfg_fifo.sv
// Host write FIFO: DEPTH entries of W bits, pointer-with-wrap-bit full/empty.
module adc083000_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc083000_cfg_sequencer.sv
// Feeds the ADC083000 serial-interface serializer: init table first, then
// queued host writes, one word per spi_start with a chip-select idle gap.
module adc083000_cfg_sequencer
  import adc083000_cfg_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 8,
  parameter int INIT_ENABLE   = 1
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic [3:0]  host_addr,
  input  logic [15:0] host_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        init_req,
  output logic [3:0]  spi_addr,
  output logic [15:0] spi_data,
  output logic        spi_start,
  input  logic        spi_cs,
  output logic        busy,
  output logic        init_done,
  output logic        err_timeout,
  input  logic        err_clr,
  output logic [15:0] words_sent
);

  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  state_e           state_q, state_d;
  cfg_word_t        word_q, word_d;
  logic             cur_host_q, cur_host_d;   // word in flight came from the FIFO
  logic             cur_last_q, cur_last_d;   // word in flight is the last init entry
  logic             pend_q, pend_d;           // init table (re)run outstanding
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             arm_q;                    // low only on the first cycle out of reset
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q;
  logic [15:0]      words_q;

  logic             fifo_full, fifo_empty, fifo_pop;
  cfg_word_t        fifo_head;
  logic             tmo_hit, gap_hit, tmo_fire, cs_seen, capture;

  adc083000_cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (sclk),
    .rst_n   (reset_n),
    .push_i  (host_valid),
    .wdata_i ({host_addr, host_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // tmo_q counts cycles since spi_start (LOAD is cycle 1); gap_q counts
  // spi_cs-low cycles, starting with the cycle the fall or timeout is seen.
  assign tmo_hit  = tmo_q >= TMO_W'(START_TIMEOUT - 1);
  assign gap_hit  = gap_q >= GAP_W'(GAP_CYCLES - 1);
  assign tmo_fire = (state_q == ST_WAIT_CS) && !spi_cs && tmo_hit;
  assign cs_seen  = (state_q == ST_WAIT_CS) && spi_cs;
  assign capture  = (state_q == ST_IDLE) && (state_d == ST_LOAD);

  // State register.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pend_q || !fifo_empty) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_WAIT_CS;
      ST_WAIT_CS: begin
        if (spi_cs)       state_d = ST_SHIFT;
        else if (tmo_hit) state_d = ST_GAP;
      end
      ST_SHIFT:   if (!spi_cs) state_d = ST_GAP;
      ST_GAP:     if (gap_hit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    spi_start = (state_q == ST_LOAD);
    fifo_pop  = (state_q == ST_LOAD) && cur_host_q;
    busy      = (state_q != ST_IDLE) || !fifo_empty || pend_q;
  end

  // Word selection, init bookkeeping and cycle counters.
  always_comb begin
    word_d     = word_q;
    cur_host_d = cur_host_q;
    cur_last_d = cur_last_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;

    if (!arm_q) pend_d = (INIT_ENABLE != 0);

    // Word is latched on entry to LOAD so it is valid alongside spi_start
    // and held until the next LOAD. Pending init beats the FIFO.
    if (capture) begin
      if (pend_q) begin
        word_d     = init_word(idx_q);
        cur_host_d = 1'b0;
        cur_last_d = (idx_q == LAST_IDX);
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) pend_d = 1'b0;
      end else begin
        word_d     = fifo_head;
        cur_host_d = 1'b1;
        cur_last_d = 1'b0;
      end
    end

    if (state_q == ST_LOAD)         tmo_d = TMO_W'(1);
    else if (state_q == ST_WAIT_CS) tmo_d = tmo_q + 1'b1;

    if (tmo_fire || ((state_q == ST_SHIFT) && !spi_cs)) gap_d = GAP_W'(1);
    else if (state_q == ST_GAP)                          gap_d = gap_q + 1'b1;

    if ((state_q == ST_GAP) && gap_hit && cur_last_q) done_d = 1'b1;

    // Rerun request: the word in flight finishes, then the table restarts.
    if (init_req) begin
      pend_d     = 1'b1;
      idx_d      = '0;
      done_d     = 1'b0;
      cur_last_d = 1'b0;
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      word_q     <= '0;
      cur_host_q <= 1'b0;
      cur_last_q <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      tmo_q      <= '0;
      gap_q      <= '0;
    end else begin
      word_q     <= word_d;
      cur_host_q <= cur_host_d;
      cur_last_q <= cur_last_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      arm_q      <= 1'b1;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
    end
  end

  // Sticky timeout flag; a new timeout beats err_clr.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (tmo_fire) err_q <= 1'b1;
    else if (err_clr)  err_q <= 1'b0;
  end

  // Count of words the serializer actually started on; wraps naturally.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)    words_q <= '0;
    else if (cs_seen) words_q <= words_q + 16'd1;
  end

  assign host_ready  = !fifo_full;
  assign spi_addr    = word_q.addr;
  assign spi_data    = word_q.data;
  assign init_done   = done_q;
  assign err_timeout = err_q;
  assign words_sent  = words_q;

endmodule

// File: tb/tb_adc083000_cfg_sequencer.sv
// Directed bench for adc083000_cfg_sequencer with a serializer model.
module tb_adc083000_cfg_sequencer;

  logic        sclk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  host_addr = '0;
  logic [15:0] host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        init_req = 1'b0;
  logic [3:0]  spi_addr;
  logic [15:0] spi_data;
  logic        spi_start;
  logic        spi_cs;
  logic        busy, init_done, err_timeout;
  logic        err_clr = 1'b0;
  logic [15:0] words_sent;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  adc083000_cfg_sequencer #(
    .FIFO_DEPTH(4), .GAP_CYCLES(4), .START_TIMEOUT(8), .INIT_ENABLE(1)
  ) dut (
    .sclk(sclk), .reset_n(reset_n),
    .host_addr(host_addr), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .init_req(init_req),
    .spi_addr(spi_addr), .spi_data(spi_data), .spi_start(spi_start),
    .spi_cs(spi_cs), .busy(busy), .init_done(init_done),
    .err_timeout(err_timeout), .err_clr(err_clr), .words_sent(words_sent)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Serializer model: start at cycle t -> chip_sel high t+1..t+33.
  logic       cs_dead = 1'b0;
  logic [5:0] cs_cnt;
  always @(posedge sclk or negedge reset_n) begin
    if (!reset_n)                   cs_cnt <= '0;
    else if (spi_start && !cs_dead) cs_cnt <= 6'd33;
    else if (cs_cnt != 0)           cs_cnt <= cs_cnt - 6'd1;
  end
  assign spi_cs = (cs_cnt != 0);

  // Transaction log: starts (word, cycle), chip_sel falls, init_done rise.
  logic [19:0] log_w[$];
  int          log_t[$];
  int          fall_t[$];
  int          idone_t = -1;
  logic        cs_prev = 1'b0, idone_prev = 1'b0;
  always @(negedge sclk) begin
    if (reset_n && spi_start) begin
      log_w.push_back({spi_addr, spi_data});
      log_t.push_back(cyc);
    end
    if (cs_prev && !spi_cs) fall_t.push_back(cyc);
    if (init_done && !idone_prev) idone_t = cyc;
    cs_prev    = spi_cs;
    idone_prev = init_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (log_w.size() < n && k < 3000) begin step(); k++; end
    chk("start_cnt", log_w.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin step(); k++; end
    chk("idle", busy, 0);
  endtask

  task automatic push(input logic [19:0] w);
    int k = 0;
    {host_addr, host_data} = w;
    host_valid = 1'b1;
    while (!host_ready && k < 3000) begin step(); k++; end
    chk("push_rdy", host_ready, 1);
    step();
    host_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_start", spi_start, 0);
    chk("rst_addr", spi_addr, 0);
    chk("rst_data", spi_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idone", init_done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_ready", host_ready, 1);
  endtask

  logic [19:0] init_exp [4] = '{20'h1B2FF, 20'h2007F, 20'h3807F, 20'hE00FF};
  logic [19:0] hw [5] = '{20'h4A000, 20'h5A001, 20'h6A002, 20'h7A003, 20'h8A004};
  logic [19:0] h3 [3] = '{20'hB1111, 20'hC2222, 20'hD3333};

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ta, tb;
    logic [19:0] e;
    #2 reset_n = 1'b0;
    repeat (3) step();
    chk_reset_vals();

    // Init run with five back-to-back host writes against a 4-deep FIFO.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {host_addr, host_data} = hw[i];
      host_valid = 1'b1;
      chk("rdy_accept", host_ready, 1);
      step();
    end
    host_valid = 1'b0;
    chk("fifo_full", host_ready, 0);
    chk("busy_init", busy, 1);
    {host_addr, host_data} = hw[4];
    host_valid = 1'b1;
    begin
      int k = 0;
      while (!host_ready && k < 3000) begin step(); k++; end
    end
    chk("held_until_pop", log_w.size(), 5);
    step();
    host_valid = 1'b0;
    wait_starts(9);
    wait_idle();
    for (int i = 0; i < 9; i++) begin
      e = (i < 4) ? init_exp[i] : hw[i-4];
      chk($sformatf("order%0d", i), log_w[i], e);
    end
    for (int i = 1; i < 9; i++) chk($sformatf("period%0d", i), log_t[i] - log_t[i-1], 39);
    chk("cs_fall", fall_t[3], log_t[3] + 34);
    chk("idone_lat", idone_t, fall_t[3] + 4);
    chk("idone", init_done, 1);
    chk("words9", words_sent, 9);

    // Serializer never starts: timeout, drop, err_clr, set-wins.
    cs_dead = 1'b1;
    base = log_w.size();
    push(20'h9C0DE);
    push(20'hA1234);
    wait_starts(base + 1);
    ta = log_t[base];
    step_to(ta + 7);
    chk("err_pre", err_timeout, 0);
    step_to(ta + 8);
    chk("err_set", err_timeout, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", err_timeout, 0);
    wait_starts(base + 2);
    chk("no_retry", log_w[base+1], 20'hA1234);
    tb = log_t[base+1];
    step_to(tb + 7);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("set_wins", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr2", err_timeout, 0);
    wait_idle();
    chk("words_tmo", words_sent, 9);
    cs_dead = 1'b0;

    // init_req while a host word is shifting.
    base = log_w.size();
    for (int i = 0; i < 3; i++) push(h3[i]);
    wait_starts(base + 1);
    step_to(log_t[base] + 10);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("idone_clr", init_done, 0);
    wait_starts(base + 7);
    wait_idle();
    chk("rq_h0", log_w[base], h3[0]);
    for (int i = 0; i < 4; i++) chk($sformatf("rq_init%0d", i), log_w[base+1+i], init_exp[i]);
    chk("rq_h1", log_w[base+5], h3[1]);
    chk("rq_h2", log_w[base+6], h3[2]);
    chk("rq_idone", init_done, 1);
    chk("words16", words_sent, 16);

    // Reset mid-SHIFT with two words queued.
    base = log_w.size();
    push(20'h55555);
    push(20'h66666);
    push(20'h77777);
    wait_starts(base + 1);
    step_to(log_t[base] + 10);
    reset_n = 1'b0;
    step();
    chk_reset_vals();
    step();
    log_w.delete();
    log_t.delete();
    fall_t.delete();
    reset_n = 1'b1;
    wait_starts(4);
    wait_idle();
    repeat (60) step();
    chk("rst_only_init", log_w.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_init%0d", i), log_w[i], init_exp[i]);
    chk("rst_words4", words_sent, 4);

    // words_sent wrap.
    force dut.words_q = 16'hFFFF;
    step();
    release dut.words_q;
    step();
    chk("preload", words_sent, 16'hFFFF);
    push(20'hFBEEF);
    wait_starts(5);
    wait_idle();
    chk("wrap_word", log_w[4], 20'hFBEEF);
    chk("wrap", words_sent, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
